// File: rtl/key_remap_writer_if.sv
// Remap RAM write/read port shared by the key remap programmer and the RAM.
`timescale 1ns/1ps

interface key_remap_writer_if #(
  parameter int unsigned KEY_BITS = 7
);
  logic                ram_rw;
  logic [KEY_BITS-1:0] ram_addr;
  logic [KEY_BITS-1:0] ram_in;
  logic [KEY_BITS-1:0] ram_out;

  modport master (output ram_rw, output ram_addr, output ram_in, input ram_out);
  modport slave  (input ram_rw, input ram_addr, input ram_in, output ram_out);
endinterface

// File: rtl/key_remap_writer.sv
// Interactive note-key remap programmer: debounced source/destination key capture,
// one-hot write into the remap RAM, then readback verification.
`timescale 1ns/1ps

module key_remap_writer #(
  parameter int unsigned KEY_BITS        = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [KEY_BITS-1:0] keys,
  key_remap_writer_if.master  ram,
  output logic                busy,
  output logic [1:0]          phase,
  output logic                done,
  output logic                err,
  output logic                err_kind
);

  localparam int unsigned SW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SRC, S_REL_SRC, S_WAIT_DST, S_REL_DST, S_WRITE, S_READ, S_VERIFY
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       stab_q, stab_d, stab_inc;
  logic [TW-1:0]       tmo_q, tmo_d, tmo_inc;
  logic [KEY_BITS-1:0] src_q, src_d, dst_q, dst_d, keys_prev_q;
  logic                key_onehot, waiting, qualify;

  logic                ram_rw_q, ram_rw_d, busy_d, done_d, err_d, err_kind_d;
  logic [KEY_BITS-1:0] ram_addr_q, ram_addr_d, ram_in_q, ram_in_d;
  logic [1:0]          phase_d;

  assign ram.ram_rw   = ram_rw_q;
  assign ram.ram_addr = ram_addr_q;
  assign ram.ram_in   = ram_in_q;

  // Saturating increments; both counters stop at their terminal value.
  assign stab_inc   = (stab_q == SW'(DEBOUNCE_CYCLES)) ? stab_q : stab_q + SW'(1);
  assign tmo_inc    = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
  assign key_onehot = (keys != '0) && ((keys & (keys - KEY_BITS'(1))) == '0);
  assign waiting    = (state_q == S_WAIT_SRC) || (state_q == S_WAIT_DST);
  assign qualify    = waiting ? (key_onehot && (keys == keys_prev_q)) : (keys == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    tmo_d      = tmo_q;
    src_d      = src_q;
    dst_d      = dst_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_kind_d = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) state_d = S_WAIT_SRC;

      S_WAIT_SRC, S_REL_SRC, S_WAIT_DST, S_REL_DST: begin
        tmo_d = tmo_inc;
        // abort outranks timeout, which outranks press/release acceptance
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (qualify) begin
          stab_d = stab_inc;
          if (stab_inc == SW'(DEBOUNCE_CYCLES)) begin
            unique case (state_q)
              S_WAIT_SRC: begin state_d = S_REL_SRC; src_d = keys; end
              S_REL_SRC:  state_d = S_WAIT_DST;
              S_WAIT_DST: begin state_d = S_REL_DST; dst_d = keys; end
              default:    state_d = S_WRITE;
            endcase
          end
        end else begin
          stab_d = '0;
        end
      end

      S_WRITE: state_d = S_READ;
      S_READ:  state_d = S_VERIFY;

      S_VERIFY: begin
        state_d = S_IDLE;
        if (ram.ram_out == dst_q) begin
          done_d = 1'b1;
        end else begin
          err_d      = 1'b1;
          err_kind_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      stab_d = '0;
      tmo_d  = '0;
    end

    // Registered outputs are decoded from the state being entered.
    ram_rw_d   = (state_d == S_WRITE);
    ram_addr_d = ((state_d == S_WRITE) || (state_d == S_READ)) ? src_d : '0;
    ram_in_d   = (state_d == S_WRITE) ? dst_d : '0;
    busy_d     = (state_d != S_IDLE);
    unique case (state_d)
      S_WAIT_SRC, S_REL_SRC:      phase_d = 2'd1;
      S_WAIT_DST, S_REL_DST:      phase_d = 2'd2;
      S_WRITE, S_READ, S_VERIFY:  phase_d = 2'd3;
      default:                    phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q      <= '0;
      tmo_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      keys_prev_q <= '0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_in_q    <= '0;
      busy        <= 1'b0;
      phase       <= 2'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_kind    <= 1'b0;
    end else begin
      stab_q      <= stab_d;
      tmo_q       <= tmo_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      keys_prev_q <= keys;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_in_q    <= ram_in_d;
      busy        <= busy_d;
      phase       <= phase_d;
      done        <= done_d;
      err         <= err_d;
      err_kind    <= err_kind_d;
    end
  end

endmodule

// File: tb/tb_key_remap_writer.sv
// Randomized bench for key_remap_writer: session-level reference model feeding a
// scoreboard of expected RAM writes and done/err pulses, checked by a monitor.
`timescale 1ns/1ps

module tb_key_remap_writer;

  localparam int unsigned KB  = 7;
  localparam int unsigned DEB = 2;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [KB-1:0] keys;
  logic          busy, done, err, err_kind;
  logic [1:0]    phase;

  key_remap_writer_if #(.KEY_BITS(KB)) ram_bus ();

  key_remap_writer #(
    .KEY_BITS(KB), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .keys(keys),
    .ram(ram_bus), .busy(busy), .phase(phase), .done(done), .err(err), .err_kind(err_kind)
  );

  always #5 clk = ~clk;

  // Remap RAM model: registered read, optional forced readback value.
  logic [KB-1:0] mem [0:(1<<KB)-1];
  bit            corrupt = 1'b0;
  logic [KB-1:0] corrupt_val = '0;
  always @(posedge clk) begin
    if (ram_bus.ram_rw) mem[ram_bus.ram_addr] <= ram_bus.ram_in;
    ram_bus.ram_out <= corrupt ? corrupt_val : mem[ram_bus.ram_addr];
  end

  typedef enum int {EV_WRITE = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [KB-1:0] addr;
    logic [KB-1:0] data;
    logic          ekind;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  wr_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [KB-1:0] a, input logic [KB-1:0] d, input logic ek);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.ekind = ek;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [KB-1:0] a, input logic [KB-1:0] d, input logic ek);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d addr %b data %b ekind %0d, expected nothing", k, a, d, ek);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (e.kind == EV_WRITE) begin
      chk("write_addr", int'(a), int'(e.addr));
      chk("write_data", int'(d), int'(e.data));
      wr_cyc = cyc;
    end else if (e.kind == EV_ERR) begin
      chk("err_kind", int'(ek), int'(e.ekind));
    end
    if (e.kind == EV_DONE || (e.kind == EV_ERR && e.ekind))
      chk("commit_latency", cyc - wr_cyc, 3);
  endtask

  // Monitor: every RAM write and every done/err pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_bus.ram_rw) observe(EV_WRITE, ram_bus.ram_addr, ram_bus.ram_in, 1'b0);
      if (done)           observe(EV_DONE, '0, '0, 1'b0);
      if (err)            observe(EV_ERR, '0, '0, err_kind);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [KB-1:0] rand_key();
    logic [KB-1:0] k;
    k = KB'(1);
    return k << $urandom_range(0, KB - 1);
  endfunction

  task automatic begin_session();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_phase", int'(phase), 1);
  endtask

  // mode: 0 normal, 1 abort at destination acceptance, 2 abort during WRITE, 3 reset during READ
  task automatic session(input logic [KB-1:0] s, input logic [KB-1:0] d,
                         input bit glitch, input bit bad_ram, input int mode);
    int n;
    begin_session();
    if (glitch) begin
      keys = 7'b0000011; tick(5);
      keys = 7'b0000001; tick(1);
      keys = '0;         tick(3);
      chk("glitch_no_latch_phase", int'(phase), 1);
    end
    keys = s;  tick($urandom_range(3, 5));
    chk("src_held_phase", int'(phase), 1);
    keys = '0; tick($urandom_range(2, 3));
    chk("src_released_phase", int'(phase), 2);

    if (mode == 1) begin
      keys = d; tick(2);
      abort = 1'b1; tick(1);
      abort = 1'b0; keys = '0;
      chk("abort_accept_busy", int'(busy), 0);
      chk("abort_accept_phase", int'(phase), 0);
      tick(4);
      return;
    end

    keys = d;  tick($urandom_range(3, 5));
    chk("dst_held_phase", int'(phase), 2);
    keys = '0; tick(1);
    push(EV_WRITE, s, d, 1'b0);
    if (mode != 3) begin
      if (bad_ram) begin
        corrupt = 1'b1;
        corrupt_val = (d == 7'b0000001) ? 7'b0000010 : 7'b0000001;
        push(EV_ERR, '0, '0, 1'b1);
      end else begin
        push(EV_DONE, '0, '0, 1'b0);
      end
    end
    tick(1);
    chk("write_phase", int'(phase), 3);
    chk("write_rw", int'(ram_bus.ram_rw), 1);

    if (mode == 2) begin
      abort = 1'b1; tick(1); abort = 1'b0;
    end

    if (mode == 3) begin
      tick(1);
      chk("read_addr", int'(ram_bus.ram_addr), int'(s));
      chk("read_rw", int'(ram_bus.ram_rw), 0);
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_phase", int'(phase), 0);
      chk("rst_addr", int'(ram_bus.ram_addr), 0);
      chk("rst_rw_done_err", int'({ram_bus.ram_rw, done, err, err_kind}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(1);
      return;
    end

    n = 0;
    while (busy && n < 10) begin
      tick(1);
      n++;
    end
    chk("commit_ends", int'(busy), 0);
    chk("done_with_busy_fall", int'(done), bad_ram ? 0 : 1);
    chk("addr_idle", int'(ram_bus.ram_addr), 0);
    corrupt = 1'b0;
    tick(1);
  endtask

  task automatic timeout_session(input bit in_dst);
    begin_session();
    if (in_dst) begin
      keys = rand_key(); tick(3);
      keys = '0;         tick(2);
      chk("tmo_dst_phase", int'(phase), 2);
    end
    keys = '0;
    tick(TMO - 1);
    chk("tmo_not_yet", int'(err), 0);
    chk("tmo_still_busy", int'(busy), 1);
    push(EV_ERR, '0, '0, 1'b0);
    tick(1);
    chk("tmo_err", int'(err), 1);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_phase", int'(phase), 0);
    tick(2);
  endtask

  task automatic abort_src_session();
    begin_session();
    keys = rand_key(); tick(1);
    abort = 1'b1; tick(1);
    abort = 1'b0; keys = '0;
    chk("abort_src_busy", int'(busy), 0);
    tick(3);
  endtask

  initial begin
    logic [KB-1:0] s, d;
    int m;
    rst = 1'b1; start = 1'b0; abort = 1'b0; keys = '0;
    tick(2);
    chk("reset_busy", int'(busy), 0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_ram", int'({ram_bus.ram_rw, ram_bus.ram_addr, ram_bus.ram_in}), 0);
    chk("reset_pulses", int'({done, err, err_kind}), 0);
    rst = 1'b0;
    tick(2);

    session(7'b0000100, 7'b1000000, 1'b0, 1'b0, 0);
    session(7'b0010000, rand_key(), 1'b1, 1'b0, 0);
    timeout_session(1'b0);
    timeout_session(1'b1);
    session(rand_key(), 7'b0100000, 1'b0, 1'b1, 0);
    session(rand_key(), rand_key(), 1'b0, 1'b0, 1);
    session(rand_key(), rand_key(), 1'b0, 1'b0, 2);
    session(rand_key(), rand_key(), 1'b0, 1'b0, 3);
    session(rand_key(), rand_key(), 1'b0, 1'b0, 0);
    s = rand_key();
    session(s, s, 1'b0, 1'b0, 0);
    abort_src_session();

    for (int i = 0; i < 30; i++) begin
      s = rand_key();
      d = rand_key();
      m = $urandom_range(0, 9);
      if (m == 9)      timeout_session(1'($urandom_range(0, 1)));
      else if (m == 8) abort_src_session();
      else session(s, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                   (m < 5) ? 0 : m - 4);
    end

    tick(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
